// File: rtl/seg7_to_count_decoder_if.sv
// Segment-bus and digit handshake bundle for seg7_to_count_decoder.
// The slave modport is the decoder; the master modport is the bus source and digit consumer.
interface seg7_to_count_decoder_if;
    logic [6:0] seg_i;
    logic [3:0] digit_o;
    logic       valid_o;
    logic       ready_i;
    logic       err_o;
    logic       overflow_o;

    modport master (
        output seg_i,
        output ready_i,
        input  digit_o,
        input  valid_o,
        input  err_o,
        input  overflow_o
    );

    modport slave (
        input  seg_i,
        input  ready_i,
        output digit_o,
        output valid_o,
        output err_o,
        output overflow_o
    );
endinterface

// File: rtl/seg7_to_count_decoder.sv
// Recovers a 4-bit digit from a glitch-filtered 7-segment bus (gfedcba, active-high).
// Defining SEG7_DECODE_HEX_EN also accepts the hex glyphs A,b,C,d,E,F as digits 10..15.
module seg7_to_count_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    seg7_to_count_decoder_if.slave  bus
);

    localparam logic [7:0] LAST_CNT = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0] MAX_CNT  = 8'(STABLE_CYCLES);

    logic [6:0] s1;
    logic [6:0] s2;
    logic [6:0] candidate;
    logic [6:0] last_accepted;
    logic [7:0] count;

    logic [3:0] digit_q;
    logic       valid_q;
    logic       err_q;
    logic       overflow_q;

    logic       accept;
    logic       accept_digit;
    logic       accept_err;
    logic       transfer;
    logic [3:0] dec_digit;
    logic       dec_legal;
    logic       dec_blank;

    // An event fires once per distinct pattern, the cycle its hold time completes.
    always_comb begin
        accept = ena && (s2 == candidate) && (count == LAST_CNT)
                 && (candidate != last_accepted);
    end

    always_comb begin
        dec_digit = 4'd0;
        dec_legal = 1'b1;
        dec_blank = 1'b0;
        case (candidate)
            7'h3F: dec_digit = 4'd0;
            7'h06: dec_digit = 4'd1;
            7'h5B: dec_digit = 4'd2;
            7'h4F: dec_digit = 4'd3;
            7'h66: dec_digit = 4'd4;
            7'h6D: dec_digit = 4'd5;
            7'h7D: dec_digit = 4'd6;
            7'h07: dec_digit = 4'd7;
            7'h7F: dec_digit = 4'd8;
            7'h6F: dec_digit = 4'd9;
`ifdef SEG7_DECODE_HEX_EN
            7'h77: dec_digit = 4'd10;
            7'h7C: dec_digit = 4'd11;
            7'h39: dec_digit = 4'd12;
            7'h5E: dec_digit = 4'd13;
            7'h79: dec_digit = 4'd14;
            7'h71: dec_digit = 4'd15;
`endif
            7'h00: dec_blank = 1'b1;
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        accept_digit = accept && dec_legal && !dec_blank;
        accept_err   = accept && !dec_legal;
        transfer     = valid_q && bus.ready_i;
    end

    // Synchronizer and stability filter freeze entirely while ena is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1            <= '0;
            s2            <= '0;
            candidate     <= '0;
            last_accepted <= '0;
            count         <= '0;
        end else if (ena) begin
            s1 <= bus.seg_i;
            s2 <= s1;
            if (s2 != candidate) begin
                candidate <= s2;
                count     <= '0;
            end else if (count != MAX_CNT) begin
                count <= count + 8'd1;
            end
            if (accept) begin
                last_accepted <= candidate;
            end
        end
    end

    // Single holding register: a digit arriving while the held one is stalled is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit_q    <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            err_q <= accept_err;
            if (accept_digit) begin
                if (!valid_q || bus.ready_i) begin
                    digit_q <= dec_digit;
                    valid_q <= 1'b1;
                end else begin
                    overflow_q <= 1'b1;
                end
            end else if (transfer) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.digit_o    = digit_q;
    assign bus.valid_o    = valid_q;
    assign bus.err_o      = err_q;
    assign bus.overflow_o = overflow_q;

endmodule

// File: tb/tb_seg7_to_count_decoder.sv
// Self-checking bench for seg7_to_count_decoder: directed scenarios plus randomized traffic
// checked against a history-based reference model of the filter and output register.
module tb_seg7_to_count_decoder;

    localparam int S = 4;
`ifdef SEG7_DECODE_HEX_EN
    localparam int NUM_GLYPHS = 16;
`else
    localparam int NUM_GLYPHS = 10;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic ena;

    seg7_to_count_decoder_if bus ();

    seg7_to_count_decoder #(.STABLE_CYCLES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [6:0] glyphs [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model: history of enabled samples; a value is accepted when its run
    // of identical samples (ending two samples back) reaches exactly S+1.
    logic [7:0] hist [$];
    logic [6:0] lastAcc;
    logic       expValid;
    logic [3:0] expDigit;
    logic       expErr;
    logic       expOverflow;

    function automatic int glyphIndex(input logic [6:0] p);
        for (int i = 0; i < NUM_GLYPHS; i++) begin
            if (glyphs[i] == p) return i;
        end
        return -1;
    endfunction

    task automatic applyStimulus(input logic [6:0] seg, input logic en,
                                 input logic rdy, input logic rstn);
        logic [7:0] v;
        int run;
        int idx;
        logic ev;
        @(negedge clk);
        bus.seg_i   = seg;
        ena         = en;
        bus.ready_i = rdy;
        rst_n       = rstn;
        @(posedge clk);
        if (!rstn) begin
            hist        = '{8'h80, 8'h00, 8'h00, 8'h00};
            lastAcc     = '0;
            expValid    = 1'b0;
            expDigit    = '0;
            expErr      = 1'b0;
            expOverflow = 1'b0;
        end else begin
            ev     = 1'b0;
            v      = 8'h00;
            expErr = 1'b0;
            if (en) begin
                v   = hist[hist.size() - 2];
                run = 0;
                for (int i = hist.size() - 2; i >= 0 && hist[i] == v && run <= S + 1; i--)
                    run++;
                ev = (run == S + 1) && (v[6:0] != lastAcc);
                hist.push_back({1'b0, seg});
                if (hist.size() > 64) void'(hist.pop_front());
            end
            idx = glyphIndex(v[6:0]);
            if (ev) lastAcc = v[6:0];
            if (ev && v != 8'h00 && idx < 0) expErr = 1'b1;
            if (ev && idx >= 0) begin
                if (!expValid || rdy) begin
                    expValid = 1'b1;
                    expDigit = 4'(idx);
                end else begin
                    expOverflow = 1'b1;
                end
            end else if (expValid && rdy) begin
                expValid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        applyStimulus(7'h00, 1'b1, 1'b1, 1'b0);
        applyStimulus(7'h00, 1'b1, 1'b1, 1'b0);
        tests++;
        if ({bus.digit_o, bus.valid_o, bus.err_o, bus.overflow_o} !== 7'b0) begin
            fails++;
            $display("[TB] FAIL reset_outputs got digit=%0d valid=%b err=%b ovf=%b want all 0",
                     bus.digit_o, bus.valid_o, bus.err_o, bus.overflow_o);
        end
    endtask

    task automatic test_basic();
        int nValid = 0;
        int validAt = -1;
        logic [3:0] got = 4'hF;
        applyStimulus(7'h00, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 14; i++) begin
            applyStimulus(7'h5B, 1'b1, 1'b1, 1'b1);
            tests++;
            if (bus.valid_o !== expValid) begin
                fails++;
                $display("[TB] FAIL basic_valid cycle %0d got %b want %b", i, bus.valid_o, expValid);
            end
            if (bus.valid_o === 1'b1) begin
                nValid++;
                validAt = i;
                got = bus.digit_o;
            end
        end
        tests++;
        if (nValid != 1 || validAt != S + 2 || got !== 4'd2) begin
            fails++;
            $display("[TB] FAIL basic_delivery got count=%0d at=%0d digit=%0d want count=1 at=%0d digit=2",
                     nValid, validAt, got, S + 2);
        end
    endtask

    task automatic test_glitch();
        int nValid = 0;
        logic [3:0] got = 4'hF;
        applyStimulus(7'h00, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus((i < 2) ? 7'h06 : 7'h4F, 1'b1, 1'b1, 1'b1);
            tests++;
            if (bus.valid_o !== expValid || bus.err_o !== expErr) begin
                fails++;
                $display("[TB] FAIL glitch_cycle %0d got valid=%b err=%b want valid=%b err=%b",
                         i, bus.valid_o, bus.err_o, expValid, expErr);
            end
            if (bus.valid_o === 1'b1) begin
                nValid++;
                got = bus.digit_o;
            end
        end
        tests++;
        if (nValid != 1 || got !== 4'd3) begin
            fails++;
            $display("[TB] FAIL glitch_delivery got count=%0d digit=%0d want count=1 digit=3", nValid, got);
        end
    endtask

    task automatic test_blank();
        int nFive = 0;
        int nOther = 0;
        int nErr = 0;
        logic [6:0] pat;
        applyStimulus(7'h00, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 24; i++) begin
            pat = (i >= 8 && i < 16) ? 7'h00 : 7'h6D;
            applyStimulus(pat, 1'b1, 1'b1, 1'b1);
            if (bus.valid_o === 1'b1 && bus.digit_o === 4'd5) nFive++;
            else if (bus.valid_o !== 1'b0) nOther++;
            if (bus.err_o !== 1'b0) nErr++;
        end
        tests++;
        if (nFive != 2 || nOther != 0 || nErr != 0) begin
            fails++;
            $display("[TB] FAIL blank_repeat got fives=%0d other=%0d errs=%0d want 2/0/0",
                     nFive, nOther, nErr);
        end
    endtask

    task automatic test_error();
        int nErr = 0;
        int nValid = 0;
        logic [3:0] got = 4'h0;
        applyStimulus(7'h00, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(7'h49, 1'b1, 1'b1, 1'b1);
            if (bus.err_o === 1'b1) nErr++;
            if (bus.valid_o !== 1'b0) nValid++;
        end
        tests++;
        if (nErr != 1 || nValid != 0) begin
            fails++;
            $display("[TB] FAIL illegal_pattern got errs=%0d valids=%0d want 1/0", nErr, nValid);
        end
        nErr = 0;
        nValid = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(7'h77, 1'b1, 1'b1, 1'b1);
            if (bus.err_o === 1'b1) nErr++;
            if (bus.valid_o === 1'b1) begin
                nValid++;
                got = bus.digit_o;
            end
        end
        tests++;
`ifdef SEG7_DECODE_HEX_EN
        if (nErr != 0 || nValid != 1 || got !== 4'd10) begin
            fails++;
            $display("[TB] FAIL hex_glyph got errs=%0d valids=%0d digit=%0d want 0/1/10", nErr, nValid, got);
        end
`else
        if (nErr != 1 || nValid != 0) begin
            fails++;
            $display("[TB] FAIL hex_glyph got errs=%0d valids=%0d want 1/0", nErr, nValid);
        end
`endif
    endtask

    task automatic test_overflow();
        applyStimulus(7'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(7'h07, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(7'h7F, 1'b1, 1'b0, 1'b1);
        tests++;
        if (bus.valid_o !== 1'b1 || bus.digit_o !== 4'd7 || bus.overflow_o !== 1'b1) begin
            fails++;
            $display("[TB] FAIL overflow_hold got valid=%b digit=%0d ovf=%b want 1/7/1",
                     bus.valid_o, bus.digit_o, bus.overflow_o);
        end
        applyStimulus(7'h7F, 1'b1, 1'b1, 1'b1);
        tests++;
        if (bus.valid_o !== 1'b0 || bus.overflow_o !== 1'b1) begin
            fails++;
            $display("[TB] FAIL overflow_drain got valid=%b ovf=%b want 0/1", bus.valid_o, bus.overflow_o);
        end
        applyStimulus(7'h7F, 1'b1, 1'b1, 1'b0);
        tests++;
        if (bus.overflow_o !== 1'b0) begin
            fails++;
            $display("[TB] FAIL overflow_reset got %b want 0", bus.overflow_o);
        end
    endtask

    task automatic test_ena();
        int nValid = 0;
        int validAt = -1;
        applyStimulus(7'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(7'h00, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(7'h7D, 1'b0, 1'b0, 1'b1);
            if (bus.valid_o !== 1'b0 || bus.err_o !== 1'b0) nValid++;
        end
        tests++;
        if (nValid != 0) begin
            fails++;
            $display("[TB] FAIL ena_freeze got %0d event cycles want 0", nValid);
        end
        for (int i = 0; i < 10 && validAt < 0; i++) begin
            applyStimulus(7'h7D, 1'b1, 1'b0, 1'b1);
            if (bus.valid_o === 1'b1) validAt = i;
        end
        tests++;
        if (validAt != S + 2 || bus.digit_o !== 4'd6) begin
            fails++;
            $display("[TB] FAIL ena_resume got at=%0d digit=%0d want at=%0d digit=6",
                     validAt, bus.digit_o, S + 2);
        end
        applyStimulus(7'h7D, 1'b1, 1'b0, 1'b0);
        tests++;
        if (bus.valid_o !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_mid_transfer got valid=%b want 0", bus.valid_o);
        end
    endtask

    task automatic test_random();
        logic [6:0] pat = 7'h00;
        int hold = 0;
        int r;
        applyStimulus(7'h00, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0) begin
                r = $urandom_range(0, 9);
                if (r < 6) pat = glyphs[$urandom_range(0, 15)];
                else if (r == 6) pat = 7'h00;
                else if (r == 7) pat = 7'($urandom);
                hold = $urandom_range(1, S + 5);
            end
            hold--;
            applyStimulus(pat, ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 299) != 0));
            tests++;
            if (bus.valid_o !== expValid || bus.err_o !== expErr || bus.overflow_o !== expOverflow) begin
                fails++;
                $display("[TB] FAIL random_flags cycle %0d got v=%b e=%b o=%b want v=%b e=%b o=%b",
                         i, bus.valid_o, bus.err_o, bus.overflow_o, expValid, expErr, expOverflow);
            end
            if (expValid) begin
                tests++;
                if (bus.digit_o !== expDigit) begin
                    fails++;
                    $display("[TB] FAIL random_digit cycle %0d got %0d want %0d", i, bus.digit_o, expDigit);
                end
            end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        ena         = 1'b1;
        bus.seg_i   = '0;
        bus.ready_i = 1'b1;
        test_reset();
        test_basic();
        test_glitch();
        test_blank();
        test_error();
        test_overflow();
        test_ena();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/seg7_to_count_decoder.md
Name: seg7_to_count_decoder

Overview:
- Inverse of the count-to-7-segment encoder: samples an external 7-segment bus (gfedcba, active-high, bit 0 = a), filters glitches, and recovers the 4-bit digit.
- Sits at the input pins, e.g. reading back a display or a neighbouring tile's segment outputs.
- Delivers each newly stable digit once through a valid/ready handshake and flags illegal patterns.

Parameters:
- STABLE_CYCLES, 4, consecutive synchronized cycles a pattern must hold before it is accepted (legal range 1..255).

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- ena  input  1  block enable; 0 freezes sampling and filtering
- seg_i  input  7  raw segment bus {g,f,e,d,c,b,a}
- digit_o  output  4  decoded digit, valid while valid_o=1
- valid_o  output  1  digit_o holds an undelivered digit
- ready_i  input  1  consumer accepts digit_o this cycle when valid_o=1
- err_o  output  1  one-cycle pulse: a stable pattern was illegal
- overflow_o  output  1  sticky: an accepted digit was dropped because the output was full

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Synchronizer flops, candidate, last-accepted pattern and stability counter all clear to 0.
  - Outputs: digit_o=0, valid_o=0, err_o=0, overflow_o=0.
  - Reset mid-transfer discards the held digit without delivering it.
- Input sync: two-flop synchronizer on seg_i. The second stage (s2) is the filtered signal.
- Stability filter:
  - If s2 != candidate: candidate <= s2 and counter <= 0.
  - Otherwise the counter increments, saturating at STABLE_CYCLES.
  - An accept event fires in the cycle the counter reaches STABLE_CYCLES-1 with s2==candidate, and only if candidate != last-accepted.
  - On accept, last-accepted <= candidate.
  - Result: one event per distinct stable pattern. Holding a pattern indefinitely produces no repeats.
- Latency: for a clean change, valid_o (or err_o) asserts at the edge STABLE_CYCLES+2 cycles after the first edge that samples the new seg_i value.
- Decode on accept event:
  - 0x3F->0, 0x06->1, 0x5B->2, 0x4F->3, 0x66->4, 0x6D->5, 0x7D->6, 0x07->7, 0x7F->8, 0x6F->9.
  - 0x00 (blank): updates last-accepted only. No digit, no error. This lets a repeated digit separated by a blank be delivered twice.
  - Any other pattern: err_o pulses for one cycle. No digit is produced.
- Output handshake (single holding register):
  - Transfer occurs when valid_o && ready_i. valid_o drops the next cycle unless reloaded.
  - Accept event with output empty, or with a transfer in the same cycle: digit_o loads and valid_o=1 next cycle (back-to-back, no bubble).
  - Accept event while valid_o=1 and ready_i=0: the new digit is dropped, the held digit_o is unchanged, and overflow_o <= 1.
  - overflow_o clears only by reset.
  - digit_o is stable while valid_o=1 and ready_i=0.
  - ready_i is ignored while valid_o=0.
- ena=0:
  - Synchronizer, candidate, counter and last-accepted hold. No accept events.
  - The handshake still completes, so a pending digit can drain.
  - When ena returns to 1, filtering resumes from the held state.
- Glitch shorter than STABLE_CYCLES on s2: counter restarts. If s2 returns to the accepted pattern, no event fires.

Optional Feature:
- Macro: SEG7_DECODE_HEX_EN
- Defined: additionally decodes hex glyphs 0x77->A, 0x7C->b, 0x39->C, 0x5E->d, 0x79->E, 0x71->F as digits 10..15. These are not errors.
- Undefined: these six patterns raise err_o like any other illegal pattern.

Test Plan:
- Reset then seg_i=0x5B held 10 cycles, ready_i=1, STABLE_CYCLES=4 -> valid_o high for exactly 1 cycle at edge 6 after the change, digit_o=2; no further events while 0x5B is held.
- seg_i 0x06 for 2 cycles then 0x4F held -> the 0x06 glitch is filtered; only digit 3 is delivered.
- seg_i 0x6D, then 0x00, then 0x6D, each held 8 cycles -> digit 5 delivered twice; the blank produces no valid_o and no err_o.
- seg_i=0x49 held -> err_o pulses exactly 1 cycle; valid_o stays 0. With SEG7_DECODE_HEX_EN, 0x77 yields digit_o=10; without it, 0x77 yields an err_o pulse.
- ready_i=0; deliver 7 (0x07), then 8 (0x7F) -> digit_o stays 7, overflow_o=1 and remains 1 after ready_i=1 drains the 7; then reset clears it.
- ena=0 while seg_i changes to 0x7D for 10 cycles -> no event; ena=1 -> digit 6 delivered after STABLE_CYCLES+2 cycles. Assert rst_n=0 while valid_o=1 -> valid_o=0 on the next edge.
